one_bit_alu: RTL and testbench



---
 rtl/alu_pkg.sv | 11 +
 rtl/full_adder.sv | 13 +
 rtl/one_bit_alu.sv | 82 ++++++++
 tb/tb_one_bit_alu.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control encodings for the MIPS datapath bit-slices.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder used as the carry-chain element of an ALU slice.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/one_bit_alu.sv
// One registered bit-slice of the MIPS word ALU (AND/OR/ADD/SUB/SLT/NOR, carry in/out).
// Optional ONE_BIT_ALU_SET_OUT_EN adds a registered raw-sum 'set' output for the MSB slice.
module one_bit_alu
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] op,
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       less,
  input  logic       sub,
`ifdef ONE_BIT_ALU_SET_OUT_EN
  output logic       set,
`endif
  output logic       r,
  output logic       cout
);

  // Inputs are sampled every rising edge with no enable and no handshake;
  // r/cout (and set) reflect the inputs of the previous cycle.
  logic w_bb;
  logic w_sum;
  logic w_c;
  logic w_r;
  logic r_r;
  logic r_cout;

  // sub is taken as given: the slice never re-derives it from op.
  assign w_bb = b ^ sub;

  full_adder u_full_adder (
    .i_a    (a),
    .i_b    (w_bb),
    .i_cin  (cin),
    .o_sum  (w_sum),
    .o_cout (w_c)
  );

  always_comb begin
    w_r = 1'b0;
    case (op)
      OP_AND:  w_r = a & b;
      OP_OR:   w_r = a | b;
      OP_ADD:  w_r = w_sum;
      OP_SUB:  w_r = w_sum;
      OP_SLT:  w_r = less;
      OP_NOR:  w_r = ~(a | b);
      default: w_r = 1'b0;
    endcase
  end

  // Carry is registered for every op so the chain never depends on decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r    <= 1'b0;
      r_cout <= 1'b0;
    end else begin
      r_r    <= w_r;
      r_cout <= w_c;
    end
  end

  assign r    = r_r;
  assign cout = r_cout;

`ifdef ONE_BIT_ALU_SET_OUT_EN
  logic r_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_set <= 1'b0;
    end else begin
      r_set <= w_sum;
    end
  end

  assign set = r_set;
`endif

endmodule

// File: tb/tb_one_bit_alu.sv
// Self-checking bench for one_bit_alu: directed vectors, async reset, and an op/input sweep.
module tb_one_bit_alu;

  logic       clk;
  logic       rst_n;
  logic [3:0] op;
  logic       a;
  logic       b;
  logic       cin;
  logic       less;
  logic       sub;
  logic       r;
  logic       cout;
`ifdef ONE_BIT_ALU_SET_OUT_EN
  logic       set;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // {set, r, cout}
  logic [2:0] exp_q[$];

  one_bit_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .op    (op),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .less  (less),
    .sub   (sub),
`ifdef ONE_BIT_ALU_SET_OUT_EN
    .set   (set),
`endif
    .r     (r),
    .cout  (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_bit(input string tag, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_model(input logic [3:0] f_op, input logic f_a,
                                           input logic f_b, input logic f_cin,
                                           input logic f_sub, input logic f_less);
    logic [1:0] tot;
    logic       res;
    tot = {1'b0, f_a} + {1'b0, f_b ^ f_sub} + {1'b0, f_cin};
    case (f_op)
      4'b0000: res = f_a & f_b;
      4'b0001: res = f_a | f_b;
      4'b0010: res = tot[0];
      4'b0110: res = tot[0];
      4'b0111: res = f_less;
      4'b1100: res = ~(f_a | f_b);
      default: res = 1'b0;
    endcase
    return {tot[0], res, tot[1]};
  endfunction

  task automatic set_inputs(input logic [3:0] t_op, input logic t_a, input logic t_b,
                            input logic t_cin, input logic t_sub, input logic t_less);
    op   = t_op;
    a    = t_a;
    b    = t_b;
    cin  = t_cin;
    sub  = t_sub;
    less = t_less;
  endtask

  // Called at a falling edge: drive, then check one cycle later at the next falling edge.
  task automatic run_vec(input string tag, input logic [3:0] t_op, input logic t_a,
                         input logic t_b, input logic t_cin, input logic t_sub,
                         input logic t_less, input logic [2:0] t_exp);
    logic [2:0] e;
    set_inputs(t_op, t_a, t_b, t_cin, t_sub, t_less);
    exp_q.push_back(t_exp);
    @(negedge clk);
    e = exp_q.pop_front();
    check_bit({tag, ".r"}, r, e[1]);
    check_bit({tag, ".cout"}, cout, e[0]);
`ifdef ONE_BIT_ALU_SET_OUT_EN
    check_bit({tag, ".set"}, set, e[2]);
`endif
  endtask

  initial begin
    logic [3:0] ops[9];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0101, 4'b1111, 4'b0011};

    rst_n = 1'b0;
    set_inputs(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    @(negedge clk);
    check_bit("rst.r", r, 1'b0);
    check_bit("rst.cout", cout, 1'b0);
    set_inputs(4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check_bit("rst_hold.r", r, 1'b0);
    check_bit("rst_hold.cout", cout, 1'b0);

    rst_n = 1'b1;
    run_vec("release_or", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110);

    run_vec("and_0_1",  4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100);
    run_vec("or_0_1",   4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110);
    run_vec("add_1_1",  4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001);
    run_vec("sub_1_1",  4'b0110, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b110);
    run_vec("slt_l1",   4'b0111, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b110);
    run_vec("nor_1_0",  4'b1100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100);
    run_vec("nor_0_0",  4'b1100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    run_vec("unused5",  4'b0101, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b101);
    run_vec("add_sub1", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001);

    // Load r=1, cout=1, then pull reset between edges.
    run_vec("pre_rst",  4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b011);
    #2 rst_n = 1'b0;
    #1;
    check_bit("async_rst.r", r, 1'b0);
    check_bit("async_rst.cout", cout, 1'b0);
`ifdef ONE_BIT_ALU_SET_OUT_EN
    check_bit("async_rst.set", set, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("post_rst", 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001);

    foreach (ops[k]) begin
      for (int v = 0; v < 32; v++) begin
        logic [4:0] bits;
        bits = 5'(v);
        run_vec($sformatf("sweep_op%0h_v%0d", ops[k], v), ops[k], bits[0], bits[1], bits[2],
                bits[3], bits[4], ref_model(ops[k], bits[0], bits[1], bits[2], bits[3], bits[4]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
